word_serializer: RTL



---
 rtl/word_serializer_pkg.sv | 39 +++
 rtl/word_serializer_if.sv | 52 +++++
 rtl/word_serializer.sv | 112 +++++++++++
 3 files changed

// File: rtl/word_serializer_pkg.sv
// -----------------------------------------------------------------------------
// word_serializer_pkg
//
// Shared definitions for the wide-element FIFO stage and the word serializer
// that drains it. Both sides take their element and word widths from here so
// they cannot drift apart.
//
// Contents:
//   DATA_WIDTH_DEF  default width of one output word
//   WORDS_DEF       default number of words per wide element
//   ELEM_WIDTH_DEF  default element width (DATA_WIDTH_DEF * WORDS_DEF)
//   IDX_W_DEF       default word-index width, never less than 1
//   word_t, elem_t  word and element vectors at the default widths
//   ser_state_e     serializer FSM state (IDLE / SEND, i.e. the busy flag)
//   idx_width()     index width for an arbitrary WORDS value
// -----------------------------------------------------------------------------
package word_serializer_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 32;
   localparam int unsigned WORDS_DEF      = 4;
   localparam int unsigned ELEM_WIDTH_DEF = DATA_WIDTH_DEF * WORDS_DEF;

   // Width of a word index; a single-word element still gets a 1-bit index.
   function automatic int unsigned idx_width(input int unsigned words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

   localparam int unsigned IDX_W_DEF = (WORDS_DEF > 1) ? $clog2(WORDS_DEF) : 1;

   typedef logic [DATA_WIDTH_DEF-1:0] word_t;
   typedef logic [ELEM_WIDTH_DEF-1:0] elem_t;

   // The serializer state is exactly the busy flag: StIdle = 0, StSend = 1.
   typedef enum logic {
      StIdle = 1'b0,
      StSend = 1'b1
   } ser_state_e;

endpackage

// File: rtl/word_serializer_if.sv
// -----------------------------------------------------------------------------
// word_serializer_if
//
// Bundles the two handshakes around the serializer:
//   upstream   : in_first / in_first_rdy / in_deq_rdy / in_deq_ena
//                (head of a single-entry wide FIFO, dequeued by the consumer)
//   downstream : out_enq_v / out_enq_rdy / out_enq_ena
//                (enq-style push of one narrow word per cycle)
//
// Modports:
//   master : the serializer (drives in_deq_ena, out_enq_v, out_enq_ena)
//   slave  : the surrounding stages (drive head, ready flags)
// -----------------------------------------------------------------------------
interface word_serializer_if
   import word_serializer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned WORDS      = WORDS_DEF
);

   // Upstream FIFO head
   logic [DATA_WIDTH*WORDS-1:0] in_first;
   logic                        in_first_rdy;
   logic                        in_deq_rdy;
   logic                        in_deq_ena;

   // Downstream word push
   logic [DATA_WIDTH-1:0]       out_enq_v;
   logic                        out_enq_rdy;
   logic                        out_enq_ena;

   modport master (
      input  in_first,
      input  in_first_rdy,
      input  in_deq_rdy,
      output in_deq_ena,
      output out_enq_v,
      input  out_enq_rdy,
      output out_enq_ena
   );

   modport slave (
      output in_first,
      output in_first_rdy,
      output in_deq_rdy,
      input  in_deq_ena,
      input  out_enq_v,
      output out_enq_rdy,
      input  out_enq_ena
   );

endinterface

// File: rtl/word_serializer.sv
// -----------------------------------------------------------------------------
// word_serializer
//
// Dequeues one wide element from the upstream single-entry FIFO, buffers it
// and pushes it downstream as WORDS narrow words, least-significant first.
// When the last word is accepted and a new head is waiting, the next element
// is loaded in the same cycle, so elements stream with no bubble.
//
// Ports:
//   CLK   clock, all state changes on posedge
//   nRST  synchronous active-low reset; gates both enables while low
//   bus   word_serializer_if.master
//           in_first, in_first_rdy, in_deq_rdy -> in_deq_ena
//           out_enq_rdy                        -> out_enq_v, out_enq_ena
// -----------------------------------------------------------------------------
module word_serializer
   import word_serializer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned WORDS      = WORDS_DEF
) (
   input logic                 CLK,
   input logic                 nRST,
   word_serializer_if.master   bus
);

   localparam int unsigned IDX_W = idx_width(WORDS);

   // Element viewed as an array of words; entry 0 is the first word sent.
   typedef logic [WORDS-1:0][DATA_WIDTH-1:0] elem_words_t;

   ser_state_e       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   elem_words_t      elem_q, elem_d;

   logic busy;
   logic last;
   logic deq_ena;
   logic enq_ena;

   // --------------------------------------------------------------------------
   // Handshake decode
   // --------------------------------------------------------------------------
   assign busy = (state_q == StSend);
   assign last = busy && (idx_q == IDX_W'(WORDS - 1));

   // A send is offered whenever a word is buffered; it completes on RDY.
   assign enq_ena = nRST && busy && bus.out_enq_rdy;

   // Take a new head when empty, or when the last word leaves this cycle.
   assign deq_ena = nRST && bus.in_first_rdy && bus.in_deq_rdy &&
                    (!busy || (last && bus.out_enq_rdy));

   assign bus.in_deq_ena  = deq_ena;
   assign bus.out_enq_ena = enq_ena;
   assign bus.out_enq_v   = elem_q[idx_q];

   // --------------------------------------------------------------------------
   // Next-state
   // --------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      elem_d  = elem_q;

      unique case (state_q)
         StIdle: begin
            if (deq_ena) begin
               elem_d  = bus.in_first;
               idx_d   = '0;
               state_d = StSend;
            end
         end

         StSend: begin
            if (enq_ena) begin
               if (!last) begin
                  idx_d = idx_q + IDX_W'(1);
               end else if (deq_ena) begin
                  // Zero-bubble reload: stay in SEND with the new element.
                  elem_d = bus.in_first;
                  idx_d  = '0;
               end else begin
                  idx_d   = '0;
                  state_d = StIdle;
               end
            end
         end

         default: begin
            state_d = StIdle;
            idx_d   = '0;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // State registers (synchronous reset). Unsent words are simply dropped.
   // --------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= StIdle;
         idx_q   <= '0;
         elem_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         elem_q  <= elem_d;
      end
   end

endmodule
